lc3_mem_port: RTL and testbench

Parametrised memory-access unit for the LC-3 core, succeeding the fixed single-cycle MAR/MDR pair. It holds MAR and MDR, loads them from the shared datapath bus, and runs read/write transactions to a variable-latency memory over a valid/ready handshake. The control FSM issues rd_req/wr_req and stalls on busy until done.

---
 rtl/lc3_mem_pkg.sv | 27 ++
 rtl/lc3_mem_timer.sv | 41 ++++
 rtl/lc3_mem_port.sv | 164 ++++++++++++++++
 tb/tb_lc3_mem_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// ============================================================================
// Module : lc3_mem_pkg
// Brief  : Shared types and default widths for the LC-3 memory-access unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lc3_mem_pkg;

  localparam int c_DATA_W      = 16;
  localparam int c_ADDR_W      = 16;
  localparam int c_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

`default_nettype wire

// File: rtl/lc3_mem_timer.sv
// ============================================================================
// Module : lc3_mem_timer
// Brief  : Saturating wait-cycle counter with synchronous clear, count enable
//          and an expire flag raised when the count equals LIMIT.
//          Only built when LC3_MEM_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef LC3_MEM_TIMEOUT_EN
module lc3_mem_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Count wait cycles; clear wins over enable, and the count holds at LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == CNT_W'(LIMIT));

endmodule
`endif

`default_nettype wire

// File: rtl/lc3_mem_port.sv
// ============================================================================
// Module : lc3_mem_port
// Brief  : LC-3 memory-access unit. Holds MAR/MDR, loads them from the
//          datapath bus and runs read/write transactions to a variable
//          latency memory over a valid/ready handshake.
//          Optional macro LC3_MEM_TIMEOUT_EN adds a wait-cycle abort with a
//          sticky error flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lc3_mem_port
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W      = c_DATA_W,
  parameter int ADDR_W      = c_ADDR_W,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_bus_in,
  input  logic              i_ld_mar,
  input  logic              i_ld_mdr,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mar,
  output logic [DATA_W-1:0] o_mdr,
  output logic              o_mem_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // Reject configurations where the MAR cannot be taken from the bus.
  if (ADDR_W > DATA_W || TIMEOUT_CYC < 1) begin : g_param_check
    $error("lc3_mem_port: need ADDR_W <= DATA_W and TIMEOUT_CYC >= 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  op_t               r_op;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;

  logic w_busy;
  logic w_done;
  logic w_accept;     // new request taken this cycle (IDLE or DONE)
  logic w_complete;   // memory finished the request this cycle
  logic w_abort;      // wait limit hit without mem_ready

  assign w_accept   = !w_busy && (i_rd_req || i_wr_req);
  assign w_complete = w_busy && i_mem_ready;

`ifdef LC3_MEM_TIMEOUT_EN
  logic w_expire;
  logic r_err;

  lc3_mem_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_accept),
    .i_en     (w_busy && !i_mem_ready),
    .o_expire (w_expire)
  );

  assign w_abort = w_busy && !i_mem_ready && w_expire;

  // Sticky timeout flag, cleared by the next accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_abort = 1'b0;
  assign o_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rd_req || i_wr_req) w_state_nxt = REQ;
      end
      REQ: begin
        w_busy = 1'b1;
        if (i_mem_ready || w_abort) w_state_nxt = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        // Back-to-back request skips IDLE.
        w_state_nxt = (i_rd_req || i_wr_req) ? REQ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the operation at acceptance; a simultaneous read beats a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= OP_RD;
    end else if (w_accept) begin
      r_op <= i_rd_req ? OP_RD : OP_WR;
    end
  end

  // MAR loads from the bus only while no transaction is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mar <= '0;
    end else if (!w_busy && i_ld_mar) begin
      r_mar <= i_bus_in[ADDR_W-1:0];
    end
  end

  // MDR takes read data on completion, or a bus load while not busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mdr <= '0;
    end else if (w_complete && (r_op == OP_RD)) begin
      r_mdr <= i_mem_rdata;
    end else if (!w_busy && i_ld_mdr) begin
      r_mdr <= i_bus_in;
    end
  end

  // MAR/MDR cannot change during REQ, so the request fields hold stable.
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_mar       = r_mar;
  assign o_mdr       = r_mdr;
  assign o_mem_valid = w_busy;
  assign o_mem_we    = w_busy && (r_op == OP_WR);
  assign o_mem_addr  = r_mar;
  assign o_mem_wdata = r_mdr;

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_port.sv
// ============================================================================
// Module : tb_lc3_mem_port
// Brief  : Self-checking bench for lc3_mem_port: directed scenarios with
//          literal expectations plus randomized traffic against a
//          transaction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lc3_mem_port;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_in = '0;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy, done, err, mem_valid, mem_we;
  logic [15:0] mar, mdr, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  lc3_mem_port #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_bus_in    (bus_in),
    .i_ld_mar    (ld_mar),
    .i_ld_mdr    (ld_mdr),
    .i_rd_req    (rd_req),
    .i_wr_req    (wr_req),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_mar       (mar),
    .o_mdr       (mdr),
    .o_mem_valid (mem_valid),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ready (mem_ready),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by its op,
  // its elapsed wait cycles and whether it finished last cycle.
  logic        m_inflight, m_finished, m_is_wr, m_err;
  logic [15:0] m_mar, m_mdr;
  int          m_waits;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_inflight <= 1'b0; m_finished <= 1'b0; m_is_wr <= 1'b0; m_err <= 1'b0;
      m_mar <= '0; m_mdr <= '0; m_waits <= 0;
    end else if (m_inflight) begin
      if (mem_ready) begin
        m_inflight <= 1'b0;
        m_finished <= 1'b1;
        if (!m_is_wr) m_mdr <= mem_rdata;
      end else if (TO_EN && m_waits == TO) begin
        m_inflight <= 1'b0;
        m_finished <= 1'b1;
        m_err      <= 1'b1;
      end else begin
        m_waits <= m_waits + 1;
      end
    end else begin
      m_finished <= 1'b0;
      if (ld_mar) m_mar <= bus_in;
      if (ld_mdr) m_mdr <= bus_in;
      if (rd_req || wr_req) begin
        m_inflight <= 1'b1;
        m_is_wr    <= !rd_req;
        m_waits    <= 0;
        m_err      <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy",      busy,      m_inflight);
      check("done",      done,      m_finished);
      check("err",       err,       m_err);
      check("mar",       mar,       m_mar);
      check("mdr",       mdr,       m_mdr);
      check("mem_valid", mem_valid, m_inflight);
      check("mem_we",    mem_we,    m_inflight && m_is_wr);
      check("mem_addr",  mem_addr,  m_mar);
      check("mem_wdata", mem_wdata, m_mdr);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus_in = '0; ld_mar = 0; ld_mdr = 0; rd_req = 0; wr_req = 0; mem_ready = 0;
  endtask

  initial begin
    idle();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_mar", mar, 16'h0);
    check("rst_mdr", mdr, 16'h0);
    check("rst_done", done, 1'b0);
    repeat (2) tick();
    reset = 1'b0;

    // Zero-wait read at 3000.
    tick(); bus_in = 16'h3000; ld_mar = 1;
    tick(); check("zw_mar", mar, 16'h3000); idle(); rd_req = 1;
    tick(); check("zw_valid", mem_valid, 1'b1); check("zw_we", mem_we, 1'b0);
            check("zw_addr", mem_addr, 16'h3000);
            idle(); mem_ready = 1; mem_rdata = 16'hABCD;
    tick(); check("zw_done", done, 1'b1); check("zw_mdr", mdr, 16'hABCD);
            check("model_mdr", m_mdr, 16'hABCD); idle();
    tick(); check("zw_done_once", done, 1'b0);

    // Wait-state write with ignored loads/requests while busy.
    tick(); bus_in = 16'h1234; ld_mdr = 1;
    tick(); idle(); bus_in = 16'h4001; ld_mar = 1;
    tick(); idle(); wr_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ws_valid", mem_valid, 1'b1); check("ws_we", mem_we, 1'b1);
      check("ws_addr", mem_addr, 16'h4001); check("ws_wdata", mem_wdata, 16'h1234);
      check("ws_nodone", done, 1'b0);
      idle(); bus_in = 16'hFFFF; ld_mar = 1; ld_mdr = 1; rd_req = 1;
      if (i == 3) mem_ready = 1;
      mem_rdata = 16'h5555;
    end
    tick(); check("ws_done", done, 1'b1); check("ws_mdr", mdr, 16'h1234);
            check("ws_mar", mar, 16'h4001);
            idle(); rd_req = 1;
    tick(); check("b2b_valid", mem_valid, 1'b1); check("b2b_we", mem_we, 1'b0);
            idle(); mem_ready = 1; mem_rdata = 16'h0BEE;
    tick(); check("b2b_done", done, 1'b1); check("b2b_mdr", mdr, 16'h0BEE); idle();

    // Simultaneous read+write with a MAR load: read at the new address.
    tick(); bus_in = 16'h0050; ld_mar = 1; rd_req = 1; wr_req = 1;
    tick(); check("sim_addr", mem_addr, 16'h0050); check("sim_we", mem_we, 1'b0);
            idle(); mem_ready = 1; mem_rdata = 16'h7777;
    tick(); check("sim_mdr", mdr, 16'h7777); idle();

    // Reset asserted while a request is in flight.
    tick(); rd_req = 1;
    tick(); check("rq_valid", mem_valid, 1'b1); idle();
    #2 reset = 1'b1;
    #1;
    check("ar_valid", mem_valid, 1'b0); check("ar_busy", busy, 1'b0);
    check("ar_mar", mar, 16'h0); check("ar_mdr", mdr, 16'h0);
    @(posedge clk);
    tick(); check("ar_nodone", done, 1'b0); check("ar_busy2", busy, 1'b0);
    reset = 1'b0;

`ifdef LC3_MEM_TIMEOUT_EN
    // Timeout abort: no mem_ready at all.
    tick(); rd_req = 1;
    repeat (5) begin tick(); idle(); end
    tick(); check("to_done", done, 1'b1); check("to_err", err, 1'b1);
            check("to_mdr", mdr, 16'h0);
            rd_req = 1; mem_ready = 1; mem_rdata = 16'h2222;
    tick(); check("to_errclr", err, 1'b0); idle(); mem_ready = 1; mem_rdata = 16'h2222;
    tick(); check("to_rd_mdr", mdr, 16'h2222); idle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      tick();
      bus_in    = 16'($urandom);
      ld_mar    = ($urandom_range(0, 4) == 0);
      ld_mdr    = ($urandom_range(0, 4) == 0);
      rd_req    = ($urandom_range(0, 3) == 0);
      wr_req    = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_rdata = 16'($urandom);
    end
    tick(); idle();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
